cordic_sched: RTL and testbench
===============================

Name: cordic_sched

Overview:
- Round-robin job scheduler and sequencer for the iterative 16-bit CORDIC datapath.
- Accepts angle jobs from two requesters and loads the winning angle into the datapath.
- Steps the iteration index, freezes the datapath when finished, and presents the x/y result on a valid/ready port tagged with the requester ID.
- Sits between client logic and the datapath; replaces ad-hoc per-client control.

Parameters:
WIDTH, 16, data width of z0/x/y
N_ITER, 16, iterations per job (1..2^IDX_W)
IDX_W, 4, width of iteration index dp_i

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
req0  in  1  requester 0 job request (level; held until gnt0)
z0_a  in  WIDTH  requester 0 angle, valid while req0
req1  in  1  requester 1 job request
z0_b  in  WIDTH  requester 1 angle
gnt0  out  1  one-cycle accept pulse to requester 0
gnt1  out  1  one-cycle accept pulse to requester 1
dp_load  out  1  datapath load (initialise x,y,z from dp_z0)
dp_z0  out  WIDTH  latched job angle
dp_i  out  IDX_W  iteration index
dp_stop  out  1  datapath hold
dp_x  in  WIDTH  datapath x
dp_y  in  WIDTH  datapath y
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_x  out  WIDTH  result x
res_y  out  WIDTH  result y
res_id  out  1  requester ID of result
busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: gnt0/gnt1/dp_load/res_valid/busy=0; dp_stop=1; dp_i, dp_z0, res_x, res_y, res_id = 0; state=IDLE; rr pointer=1, so req0 wins first.
- FSM: 2-bit state; IDLE=0, LOAD=1, ITER=2, DONE=3.
- IDLE → LOAD when req0|req1:
  - At that edge, latch the winner's z0 into dp_z0 and its ID.
  - Register gnt for exactly one cycle, asserted during the LOAD cycle.
  - Update the rr pointer.
- Arbitration:
  - Only one request present: that requester wins.
  - Both present: the one not granted last wins.
- LOAD (1 cycle): dp_load=1, dp_stop=0, dp_i=0; then go to ITER.
- ITER:
  - dp_load=0, dp_stop=0.
  - dp_i starts at 0 and increments every edge.
  - On the edge where dp_i==N_ITER-1: go to DONE and set dp_i to 0.
  - Exactly N_ITER ITER cycles.
- DONE:
  - dp_stop=1.
  - On the first DONE edge with res_valid=0: capture dp_x/dp_y into res_x/res_y and latched ID into res_id; set res_valid.
  - res_x/res_y/res_id stay stable while res_valid=1.
  - Edge with res_valid & res_ready: clear res_valid; go to IDLE.
  - No grants are issued in DONE; requests wait.
- Latency: res_valid rises N_ITER+2 cycles after the LOAD cycle begins (18 for default).
- dp_stop=1 in IDLE and DONE; dp_i=0 outside ITER.
- Requests are sampled only in IDLE, except as noted in the Optional Feature.
- A requester that drops req before grant is not served.
- Reset is asynchronous at any time, including mid-ITER or with res_valid pending: all outputs go to their reset values immediately and the in-flight job is discarded.

Optional Feature:
- Macro: CORDIC_SCHED_BACK2BACK_EN.
- Defined: on the res_valid&res_ready edge, if any req is present, arbitrate and go directly to LOAD with gnt, skipping IDLE. Jobs issue every N_ITER+3 cycles.
- Undefined: always return to IDLE. Jobs issue every N_ITER+4 cycles at best.

Decomposition:
- Package cordic_sched_pkg:
  - state encoding constants IDLE/LOAD/ITER/DONE
  - default WIDTH/N_ITER/IDX_W
- One natural sub-module, cordic_rr_arb2: 2-way round-robin arbiter with pointer update on accept. FSM, counter and result registers stay in the top.

Test Plan:
1. reset asserted with req0=1 → gnt=0, dp_stop=1, dp_i=0, res_valid=0, busy=0; after release, gnt0 pulses next edge.
2. req0=1, z0_a=16'h2000, res_ready=1 → gnt0 single pulse; dp_load 1 cycle with dp_z0=16'h2000; dp_i 0..15 over 16 cycles; res_valid 18 cycles after LOAD start; res_id=0; res_x/res_y equal dp_x/dp_y frozen in DONE.
3. req0 and req1 raised same cycle, z0_a=16'h1000, z0_b=16'h3000 → job 0 first, then job 1 with dp_z0=16'h3000; res_id 0 then 1; next simultaneous pair grants req0.
4. res_ready low for 5 cycles with req1 pending → res_valid and res_x/res_y/res_id stable; no gnt1 and dp_stop=1 throughout; gnt1 follows the handshake.
5. reset pulsed mid-ITER at dp_i=7 → outputs to reset values asynchronously; no res_valid; re-held req0 restarts at dp_i=0.
6. With CORDIC_SCHED_BACK2BACK_EN, req0 held and res_ready=1 → gnt0 pulses every 19 cycles; without the macro, every 20.

Source files
------------

// File: rtl/cordic_sched_pkg.sv
// cordic_sched_pkg: state encoding and default sizes for the CORDIC job scheduler
package cordic_sched_pkg;
  localparam int WIDTH_D  = 16;
  localparam int N_ITER_D = 16;
  localparam int IDX_W_D  = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/cordic_rr_arb2.sv
// cordic_rr_arb2: two-way round-robin arbiter; pointer remembers the last granted requester
module cordic_rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_accept,
  output logic o_valid,
  output logic o_win
);
  logic r_ptr;
  assign o_valid = i_req0 | i_req1;
  assign o_win   = (i_req0 & i_req1) ? ~r_ptr : i_req1;
  // pointer starts at 1 so requester 0 wins the first contested round
  always_ff @(posedge clk or posedge reset)
    if (reset) r_ptr <= 1'b1;
    else if (i_accept & o_valid) r_ptr <= o_win;
endmodule

// File: rtl/cordic_sched.sv
// cordic_sched: round-robin job scheduler and iteration sequencer for the CORDIC datapath
// Optional: CORDIC_SCHED_BACK2BACK_EN lets a finished job hand over straight to the next LOAD.
module cordic_sched
  import cordic_sched_pkg::*;
#(
  parameter int WIDTH  = WIDTH_D,
  parameter int N_ITER = N_ITER_D,
  parameter int IDX_W  = IDX_W_D
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] z0_a,
  input  logic             req1,
  input  logic [WIDTH-1:0] z0_b,
  output logic             gnt0,
  output logic             gnt1,
  output logic             dp_load,
  output logic [WIDTH-1:0] dp_z0,
  output logic [IDX_W-1:0] dp_i,
  output logic             dp_stop,
  input  logic [WIDTH-1:0] dp_x,
  input  logic [WIDTH-1:0] dp_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_x,
  output logic [WIDTH-1:0] res_y,
  output logic             res_id,
  output logic             busy
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ITER - 1);
  state_t           r_state, w_next;
  logic             r_gnt0, r_gnt1, r_id, r_res_id, r_valid;
  logic [WIDTH-1:0] r_z0, r_res_x, r_res_y;
  logic [IDX_W-1:0] r_i;
  logic             w_any, w_win, w_hs, w_accept;
  assign w_hs = (r_state == DONE) & r_valid & res_ready;
`ifdef CORDIC_SCHED_BACK2BACK_EN
  assign w_accept = w_any & ((r_state == IDLE) | w_hs);
`else
  assign w_accept = w_any & (r_state == IDLE);
`endif
  cordic_rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .i_req0  (req0),
    .i_req1  (req1),
    .i_accept(w_accept),
    .o_valid (w_any),
    .o_win   (w_win)
  );
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  // next state and state-decoded datapath controls
  always_comb begin
    w_next  = r_state;
    dp_load = r_state == LOAD;
    dp_stop = (r_state == IDLE) | (r_state == DONE);
    busy    = r_state != IDLE;
    case (r_state)
      IDLE: w_next = w_any ? LOAD : IDLE;
      LOAD: w_next = ITER;
      ITER: w_next = (r_i == LAST) ? DONE : ITER;
      DONE: w_next = w_hs ? (w_accept ? LOAD : IDLE) : DONE;
    endcase
  end
  // grant pulse, job latch, iteration index and result holding registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_z0     <= '0;
      r_id     <= 1'b0;
      r_i      <= '0;
      r_valid  <= 1'b0;
      r_res_x  <= '0;
      r_res_y  <= '0;
      r_res_id <= 1'b0;
    end else begin
      r_gnt0 <= w_accept & ~w_win;
      r_gnt1 <= w_accept & w_win;
      if (w_accept) begin
        r_z0 <= w_win ? z0_b : z0_a;
        r_id <= w_win;
      end
      r_i <= (r_state == ITER && r_i != LAST) ? r_i + IDX_W'(1) : '0;
      if (r_state == DONE && !r_valid) begin
        r_res_x  <= dp_x;
        r_res_y  <= dp_y;
        r_res_id <= r_id;
        r_valid  <= 1'b1;
      end else if (w_hs) r_valid <= 1'b0;
    end
  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign dp_z0     = r_z0;
  assign dp_i      = r_i;
  assign res_valid = r_valid;
  assign res_x     = r_res_x;
  assign res_y     = r_res_y;
  assign res_id    = r_res_id;
endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: randomized self-checking bench for cordic_sched against a job-level model
module tb_cordic_sched;
`ifdef CORDIC_SCHED_BACK2BACK_EN
  localparam int PERIOD = 19;
`else
  localparam int PERIOD = 20;
`endif
  localparam int LAT = 18;
  logic clk = 0, reset = 1, req0 = 0, req1 = 0, res_ready = 0;
  logic [15:0] z0_a = 0, z0_b = 0, dp_x = 0, dp_y = 0;
  logic gnt0, gnt1, dp_load, dp_stop, res_valid, res_id, busy;
  logic [15:0] dp_z0, res_x, res_y;
  logic [3:0] dp_i;
  int checks = 0, errors = 0, cyc = 0;
  bit last_gnt = 1;
  logic [15:0] prev_x, prev_y;
  bit o_ok, o_id, o_load, o_rid;
  int o_tg, o_lat, o_extra;
  logic [15:0] o_z, o_rx, o_ry, o_ex, o_ey;
  logic [3:0] o_i [32];
  bit o_stop [32], o_ld [32];

  cordic_sched dut (
    .clk(clk), .reset(reset), .req0(req0), .z0_a(z0_a), .req1(req1), .z0_b(z0_b),
    .gnt0(gnt0), .gnt1(gnt1), .dp_load(dp_load), .dp_z0(dp_z0), .dp_i(dp_i),
    .dp_stop(dp_stop), .dp_x(dp_x), .dp_y(dp_y), .res_valid(res_valid),
    .res_ready(res_ready), .res_x(res_x), .res_y(res_y), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task tick;
    prev_x = dp_x;
    prev_y = dp_y;
    @(posedge clk);
    #1;
    cyc++;
    dp_x = 16'($urandom);
    dp_y = 16'($urandom);
  endtask

  task do_reset;
    reset = 1; req0 = 0; req1 = 0; res_ready = 0;
    repeat (2) tick;
    reset = 0;
    last_gnt = 1;
  endtask

  function automatic bit pick(input bit r0, input bit r1);
    return (r0 && r1) ? !last_gnt : r1;
  endfunction

  task observe_job;
    int n, k;
    o_ok = 0; o_extra = 0; n = 0;
    while (!(gnt0 || gnt1) && n < 80) begin tick; n++; end
    if (!(gnt0 || gnt1)) return;
    o_tg = cyc; o_id = gnt1; o_z = dp_z0; o_load = dp_load;
    if (gnt0) req0 = 0; else req1 = 0;
    n = 0;
    while (!res_valid && n < 80) begin
      tick; n++;
      k = cyc - o_tg;
      if (k < 32) begin o_i[k] = dp_i; o_stop[k] = dp_stop; o_ld[k] = dp_load; end
      if (gnt0 || gnt1) o_extra++;
    end
    if (!res_valid) return;
    o_lat = cyc - o_tg; o_rx = res_x; o_ry = res_y; o_rid = res_id;
    o_ex = prev_x; o_ey = prev_y; o_ok = 1;
  endtask

  task test_reset;
    req0 = 1; z0_a = 16'h1234;
    repeat (2) tick;
    checks++; if (gnt0 !== 0) begin errors++; $display("FAIL rst_gnt0 got %b want 0", gnt0); end
    checks++; if (dp_stop !== 1) begin errors++; $display("FAIL rst_dp_stop got %b want 1", dp_stop); end
    checks++; if (dp_i !== 0) begin errors++; $display("FAIL rst_dp_i got %0d want 0", dp_i); end
    checks++; if (res_valid !== 0) begin errors++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
    checks++; if (busy !== 0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if ({dp_load, dp_z0, res_x, res_y, res_id} !== '0) begin errors++; $display("FAIL rst_regs got %h want 0", {dp_load, dp_z0, res_x, res_y, res_id}); end
    reset = 0;
    tick;
    checks++; if ({gnt0, gnt1, dp_load} !== 3'b101) begin errors++; $display("FAIL rst_first_gnt got %b want 101", {gnt0, gnt1, dp_load}); end
    checks++; if (dp_z0 !== 16'h1234) begin errors++; $display("FAIL rst_first_z0 got %h want 1234", dp_z0); end
    do_reset;
  endtask

  task test_single_job;
    bit exp;
    logic [15:0] z;
    res_ready = 1;
    for (int j = 0; j < 4; j++) begin
      z = (j == 0) ? 16'h2000 : 16'($urandom);
      if (j == 0 || $urandom_range(1)) begin req0 = 1; z0_a = z; z0_b = 16'($urandom); end
      else begin req1 = 1; z0_b = z; z0_a = 16'($urandom); end
      exp = pick(req0, req1);
      observe_job;
      last_gnt = exp;
      checks++; if (!o_ok) begin errors++; $display("FAIL job%0d_timeout got none want result", j); continue; end
      checks++; if (o_id !== exp || o_rid !== exp) begin errors++; $display("FAIL job%0d_id got gnt %b res %b want %b", j, o_id, o_rid, exp); end
      checks++; if (o_z !== z || !o_load) begin errors++; $display("FAIL job%0d_load got z %h load %b want %h 1", j, o_z, o_load, z); end
      for (int k = 1; k <= 16; k++) begin
        checks++; if (o_i[k] !== 4'(k - 1) || o_stop[k] || o_ld[k]) begin errors++; $display("FAIL job%0d_iter%0d got i %0d stop %b load %b want %0d 0 0", j, k, o_i[k], o_stop[k], o_ld[k], k - 1); end
      end
      checks++; if (o_i[17] !== 0 || !o_stop[17] || o_ld[17]) begin errors++; $display("FAIL job%0d_done got i %0d stop %b want 0 1", j, o_i[17], o_stop[17]); end
      checks++; if (o_lat !== LAT || o_extra != 0) begin errors++; $display("FAIL job%0d_latency got %0d extra %0d want %0d 0", j, o_lat, o_extra, LAT); end
      checks++; if (o_rx !== o_ex || o_ry !== o_ey) begin errors++; $display("FAIL job%0d_result got %h %h want %h %h", j, o_rx, o_ry, o_ex, o_ey); end
      tick;
      checks++; if (res_valid !== 0 || busy !== 0) begin errors++; $display("FAIL job%0d_release got valid %b busy %b want 0 0", j, res_valid, busy); end
    end
    do_reset;
  endtask

  task test_simultaneous;
    bit exp;
    logic [15:0] z;
    res_ready = 1;
    for (int r = 0; r < 9; r++) begin
      if (r == 0) begin req0 = 1; req1 = 1; z0_a = 16'h1000; z0_b = 16'h3000; end
      else if (r == 2) begin req0 = 1; req1 = 1; end
      else if (r > 2) begin
        if (!req0 && $urandom_range(1)) begin req0 = 1; z0_a = 16'($urandom); end
        if (!req1 && $urandom_range(1)) begin req1 = 1; z0_b = 16'($urandom); end
        if (!req0 && !req1) begin req0 = 1; z0_a = 16'($urandom); end
      end
      exp = pick(req0, req1);
      z = exp ? z0_b : z0_a;
      observe_job;
      last_gnt = exp;
      checks++; if (!o_ok) begin errors++; $display("FAIL rr%0d_timeout got none want result", r); continue; end
      checks++; if (o_id !== exp || o_rid !== exp) begin errors++; $display("FAIL rr%0d_id got gnt %b res %b want %b", r, o_id, o_rid, exp); end
      checks++; if (o_z !== z) begin errors++; $display("FAIL rr%0d_z0 got %h want %h", r, o_z, z); end
      checks++; if (o_lat !== LAT || o_rx !== o_ex) begin errors++; $display("FAIL rr%0d_result got lat %0d x %h want %0d %h", r, o_lat, o_rx, LAT, o_ex); end
    end
    do_reset;
  endtask

  task test_backpressure;
    logic [15:0] sx, sy;
    bit g_hs, g_next;
    req0 = 1; z0_a = 16'($urandom);
    observe_job;
    req1 = 1; z0_b = 16'($urandom);
    sx = res_x; sy = res_y;
    checks++; if (!o_ok || o_rid !== 0 || o_rx !== o_ex) begin errors++; $display("FAIL bp_result got ok %b id %b x %h want 1 0 %h", o_ok, o_rid, o_rx, o_ex); end
    for (int c = 0; c < 5; c++) begin
      tick;
      checks++; if ({res_valid, res_x, res_y, res_id, gnt1, dp_stop} !== {1'b1, sx, sy, 1'b0, 1'b0, 1'b1}) begin
        errors++; $display("FAIL bp_hold%0d got v %b x %h y %h id %b g %b s %b want 1 %h %h 0 0 1", c, res_valid, res_x, res_y, res_id, gnt1, dp_stop, sx, sy);
      end
    end
    res_ready = 1;
    tick; g_hs = gnt1;
    checks++; if (res_valid !== 0) begin errors++; $display("FAIL bp_handshake got %b want 0", res_valid); end
    tick; g_next = gnt1;
    checks++; if ({g_hs, g_next} !== ((PERIOD == 19) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL bp_gnt1 got %b want %b", {g_hs, g_next}, (PERIOD == 19) ? 2'b10 : 2'b01); end
    checks++; if (dp_z0 !== z0_b) begin errors++; $display("FAIL bp_z0b got %h want %h", dp_z0, z0_b); end
    do_reset;
  endtask

  task test_reset_mid;
    int n, seen;
    req0 = 1; z0_a = 16'($urandom); res_ready = 1; n = 0;
    while (!gnt0 && n < 80) begin tick; n++; end
    req0 = 0; n = 0;
    while (dp_i != 7 && n < 40) begin tick; n++; end
    checks++; if (dp_i !== 7 || !busy) begin errors++; $display("FAIL mid_reach got i %0d busy %b want 7 1", dp_i, busy); end
    #2 reset = 1;
    #1;
    checks++; if ({busy, dp_stop, dp_i, dp_load, gnt0, res_valid, dp_z0} !== {1'b0, 1'b1, 4'd0, 3'b000, 16'h0}) begin
      errors++; $display("FAIL mid_async got busy %b stop %b i %0d load %b v %b z %h want 0 1 0 0 0 0", busy, dp_stop, dp_i, dp_load, res_valid, dp_z0);
    end
    @(posedge clk); #1 reset = 0; last_gnt = 1;
    seen = 0;
    repeat (25) begin tick; if (res_valid || busy) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_discard got %0d active cycles want 0", seen); end
    req0 = 1;
    observe_job;
    checks++; if (!o_ok || o_i[1] !== 0 || o_lat !== LAT || o_id !== 0) begin errors++; $display("FAIL mid_restart got ok %b i %0d lat %0d id %b want 1 0 %0d 0", o_ok, o_i[1], o_lat, o_id, LAT); end
    do_reset;
  endtask

  task test_back_to_back;
    int t [4];
    int cnt, n;
    res_ready = 1; req0 = 1; z0_a = 16'($urandom); cnt = 0; n = 0;
    while (cnt < 4 && n < 120) begin
      tick; n++;
      if (gnt0) begin t[cnt] = cyc; cnt++; end
    end
    req0 = 0;
    checks++; if (cnt != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", cnt); end
    else for (int i = 1; i < 4; i++) begin
      checks++; if (t[i] - t[i-1] != PERIOD) begin errors++; $display("FAIL b2b_period%0d got %0d want %0d", i, t[i] - t[i-1], PERIOD); end
    end
    do_reset;
  endtask

  initial begin
    test_reset;
    test_single_job;
    test_simultaneous;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
